// File: rtl/dcache_tag_stage_pkg.sv
// Shared types and constants for the L1D tag stage: vector/scalar types, decoded
// instruction layout, memory access kinds, pipeline selects and L1D geometry.
package dcache_tag_stage_pkg;

   localparam int VECTOR_LANES           = 16;
   localparam int CACHE_LINE_OFFSET_BITS = 6;
   localparam int DCACHE_WAYS            = 4;
   localparam int DCACHE_SETS            = 64;
   localparam int L1D_SET_BITS           = $clog2(DCACHE_SETS);
   localparam int L1D_WAY_BITS           = $clog2(DCACHE_WAYS);
   localparam int L1D_TAG_BITS           = 32 - CACHE_LINE_OFFSET_BITS - L1D_SET_BITS;

   typedef logic [31:0] scalar_t;
   typedef scalar_t [VECTOR_LANES-1:0] vector_t;
   typedef logic [1:0] thread_idx_t;
   typedef logic [$clog2(VECTOR_LANES)-1:0] subcycle_t;

   typedef logic [L1D_TAG_BITS-1:0] l1d_tag_t;
   typedef logic [L1D_SET_BITS-1:0] l1d_set_idx_t;
   typedef logic [L1D_WAY_BITS-1:0] l1d_way_idx_t;

   typedef enum logic [1:0] {
      PIPE_MEM,
      PIPE_INT_ARITH,
      PIPE_FLOAT_ARITH
   } pipeline_sel_t;

   typedef enum logic [3:0] {
      MEM_B,
      MEM_BX,
      MEM_S,
      MEM_SX,
      MEM_L,
      MEM_SYNC,
      MEM_CONTROL_REG,
      MEM_BLOCK,
      MEM_STRIDED,
      MEM_SCGATH
   } memory_access_type_t;

   typedef struct packed {
      logic                is_memory_access;
      logic                is_load;
      memory_access_type_t memory_access_type;
      scalar_t             immediate_value;
   } decoded_instruction_t;

   // Strided and scatter/gather accesses walk one lane per subcycle.
   function automatic logic isLaneIndexed(input memory_access_type_t accessType);
      return (accessType == MEM_STRIDED) || (accessType == MEM_SCGATH);
   endfunction

endpackage

// File: rtl/dcache_tag_stage_way.sv
// One L1D way: valid/tag arrays with a registered read port and a write port
// whose same-set write is forwarded into the read register (write-first).
module dcache_tag_way
   import dcache_tag_stage_pkg::*;
#(
   parameter int NUM_SETS = DCACHE_SETS,
   parameter int TAG_BITS = L1D_TAG_BITS
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [$clog2(NUM_SETS)-1:0] i_read_set,
   input  logic                        i_write_en,
   input  logic [$clog2(NUM_SETS)-1:0] i_write_set,
   input  logic [TAG_BITS-1:0]         i_write_tag,
   input  logic                        i_write_valid,
   output logic                        o_valid,
   output logic [TAG_BITS-1:0]         o_tag
);

   logic [NUM_SETS-1:0] r_valid;
   logic [TAG_BITS-1:0] r_tag [NUM_SETS];
   logic                r_readValid;
   logic [TAG_BITS-1:0] r_readTag;
   logic                w_bypass;

   assign w_bypass = i_write_en && (i_write_set == i_read_set);

   // Valid bits are the only state that must be cleared; tags are don't-care until valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_valid <= '0;
      else if (i_write_en)
         r_valid[i_write_set] <= i_write_valid;
   end

   always_ff @(posedge clk) begin
      if (i_write_en)
         r_tag[i_write_set] <= i_write_tag;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_readValid <= 1'b0;
         r_readTag   <= '0;
      end else begin
         r_readValid <= w_bypass ? i_write_valid : r_valid[i_read_set];
         r_readTag   <= w_bypass ? i_write_tag   : r_tag[i_read_set];
      end
   end

   assign o_valid = r_readValid;
   assign o_tag   = r_readTag;

endmodule

// File: rtl/dcache_tag_stage.sv
// L1D tag stage: effective address generation, tag array read on entry and compare on exit.
// Optional alignment checking is enabled by defining DCACHE_ALIGN_CHECK_EN.
module dcache_tag_stage
   import dcache_tag_stage_pkg::*;
#(
   parameter int NUM_WAYS = DCACHE_WAYS,
   parameter int NUM_SETS = DCACHE_SETS
) (
   input  logic                                               clk,
   input  logic                                               reset,
   input  logic                                               of_instruction_valid,
   input  decoded_instruction_t                               of_instruction,
   input  logic [VECTOR_LANES-1:0]                            of_mask_value,
   input  thread_idx_t                                        of_thread_idx,
   input  vector_t                                            of_operand1,
   input  vector_t                                            of_store_value,
   input  subcycle_t                                          of_subcycle,
   input  logic                                               fill_en,
   input  logic [$clog2(NUM_SETS)-1:0]                        fill_set,
   input  logic [$clog2(NUM_WAYS)-1:0]                        fill_way,
   input  logic [32-CACHE_LINE_OFFSET_BITS-$clog2(NUM_SETS)-1:0] fill_tag,
   input  logic                                               fill_valid,
   input  logic                                               wb_rollback_en,
   input  thread_idx_t                                        wb_rollback_thread_idx,
   input  pipeline_sel_t                                      wb_rollback_pipeline,
   output logic                                               dt_instruction_valid,
   output decoded_instruction_t                               dt_instruction,
   output logic [VECTOR_LANES-1:0]                            dt_mask_value,
   output thread_idx_t                                        dt_thread_idx,
   output scalar_t                                            dt_request_addr,
   output vector_t                                            dt_store_value,
   output subcycle_t                                          dt_subcycle,
   output logic [NUM_WAYS-1:0]                                dt_way_hit,
   output logic                                               dt_cache_hit
`ifdef DCACHE_ALIGN_CHECK_EN
   ,
   output logic                                               dt_alignment_fault
`endif
);

   localparam int SET_BITS = $clog2(NUM_SETS);
   localparam int WAY_BITS = $clog2(NUM_WAYS);
   localparam int TAG_BITS = 32 - CACHE_LINE_OFFSET_BITS - SET_BITS;

   scalar_t             w_addr;
   vector_t             w_storeValue;
   logic                w_rollback;
   logic [SET_BITS-1:0] w_lookupSet;
   logic [NUM_WAYS-1:0] w_wayValid;
   logic [TAG_BITS-1:0] w_wayTag [NUM_WAYS];
   logic [TAG_BITS-1:0] w_requestTag;
   logic                w_fault;
   logic                w_hitEnable;

   // Lane-indexed accesses pick their lane by subcycle and move that store lane to lane 0.
   always_comb begin
      w_storeValue = of_store_value;
      case (of_instruction.memory_access_type)
         MEM_STRIDED: begin
            w_addr          = of_operand1[0] + of_instruction.immediate_value * scalar_t'(of_subcycle);
            w_storeValue[0] = of_store_value[of_subcycle];
         end
         MEM_SCGATH: begin
            w_addr          = of_operand1[of_subcycle] + of_instruction.immediate_value;
            w_storeValue[0] = of_store_value[of_subcycle];
         end
         default: w_addr = of_operand1[0] + of_instruction.immediate_value;
      endcase
   end

   assign w_lookupSet = w_addr[CACHE_LINE_OFFSET_BITS +: SET_BITS];
   assign w_rollback  = wb_rollback_en && (wb_rollback_thread_idx == of_thread_idx)
                        && (wb_rollback_pipeline == PIPE_MEM);

   for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
      dcache_tag_way #(
         .NUM_SETS(NUM_SETS),
         .TAG_BITS(TAG_BITS)
      ) u_way (
         .clk          (clk),
         .reset        (reset),
         .i_read_set   (w_lookupSet),
         .i_write_en   (fill_en && (fill_way == WAY_BITS'(w))),
         .i_write_set  (fill_set),
         .i_write_tag  (fill_tag),
         .i_write_valid(fill_valid),
         .o_valid      (w_wayValid[w]),
         .o_tag        (w_wayTag[w])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dt_instruction_valid <= 1'b0;
         dt_instruction       <= '0;
         dt_mask_value        <= '0;
         dt_thread_idx        <= '0;
         dt_request_addr      <= '0;
         dt_store_value       <= '0;
         dt_subcycle          <= '0;
      end else begin
         dt_instruction_valid <= of_instruction_valid && !w_rollback;
         dt_instruction       <= of_instruction;
         dt_mask_value        <= of_mask_value;
         dt_thread_idx        <= of_thread_idx;
         dt_request_addr      <= w_addr;
         dt_store_value       <= w_storeValue;
         dt_subcycle          <= of_subcycle;
      end
   end

`ifdef DCACHE_ALIGN_CHECK_EN
   logic w_misaligned;

   always_comb begin
      case (dt_instruction.memory_access_type)
         MEM_S, MEM_SX:                   w_misaligned = dt_request_addr[0];
         MEM_L, MEM_SYNC, MEM_STRIDED,
         MEM_SCGATH:                      w_misaligned = |dt_request_addr[1:0];
         MEM_BLOCK:                       w_misaligned = |dt_request_addr[CACHE_LINE_OFFSET_BITS-1:0];
         default:                         w_misaligned = 1'b0;
      endcase
   end

   assign w_fault            = dt_instruction_valid && dt_instruction.is_memory_access && w_misaligned;
   assign dt_alignment_fault = w_fault;
`else
   assign w_fault = 1'b0;
`endif

   // I/O space (top 64KB) and faulting accesses never report a cache hit.
   assign w_requestTag = dt_request_addr[31 -: TAG_BITS];
   assign w_hitEnable  = dt_instruction_valid && dt_instruction.is_memory_access
                         && (dt_request_addr[31:16] != 16'hffff) && !w_fault;

   always_comb begin
      dt_way_hit = '0;
      for (int w = 0; w < NUM_WAYS; w++)
         dt_way_hit[w] = w_hitEnable && w_wayValid[w] && (w_wayTag[w] == w_requestTag);
   end

   assign dt_cache_hit = |dt_way_hit;

   always @(posedge clk) begin
      if (!reset)
         assert ($onehot0(dt_way_hit));
   end

endmodule

// File: tb/tb_dcache_tag_stage.sv
// Self-checking bench for dcache_tag_stage: vector table through a scoreboard queue,
// plus a hand-written reset-after-fill sequence.
module tb_dcache_tag_stage;
   import dcache_tag_stage_pkg::*;

`ifdef DCACHE_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   logic                      clk = 1'b0;
   logic                      reset;
   logic                      of_instruction_valid;
   decoded_instruction_t      of_instruction;
   logic [VECTOR_LANES-1:0]   of_mask_value;
   thread_idx_t               of_thread_idx;
   vector_t                   of_operand1;
   vector_t                   of_store_value;
   subcycle_t                 of_subcycle;
   logic                      fill_en;
   l1d_set_idx_t              fill_set;
   l1d_way_idx_t              fill_way;
   l1d_tag_t                  fill_tag;
   logic                      fill_valid;
   logic                      wb_rollback_en;
   thread_idx_t               wb_rollback_thread_idx;
   pipeline_sel_t             wb_rollback_pipeline;
   logic                      dt_instruction_valid;
   decoded_instruction_t      dt_instruction;
   logic [VECTOR_LANES-1:0]   dt_mask_value;
   thread_idx_t               dt_thread_idx;
   scalar_t                   dt_request_addr;
   vector_t                   dt_store_value;
   subcycle_t                 dt_subcycle;
   logic [DCACHE_WAYS-1:0]    dt_way_hit;
   logic                      dt_cache_hit;
   logic                      dt_alignment_fault;

   always #5 clk = ~clk;

   dcache_tag_stage #(
      .NUM_WAYS(DCACHE_WAYS),
      .NUM_SETS(DCACHE_SETS)
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .of_instruction_valid  (of_instruction_valid),
      .of_instruction        (of_instruction),
      .of_mask_value         (of_mask_value),
      .of_thread_idx         (of_thread_idx),
      .of_operand1           (of_operand1),
      .of_store_value        (of_store_value),
      .of_subcycle           (of_subcycle),
      .fill_en               (fill_en),
      .fill_set              (fill_set),
      .fill_way              (fill_way),
      .fill_tag              (fill_tag),
      .fill_valid            (fill_valid),
      .wb_rollback_en        (wb_rollback_en),
      .wb_rollback_thread_idx(wb_rollback_thread_idx),
      .wb_rollback_pipeline  (wb_rollback_pipeline),
      .dt_instruction_valid  (dt_instruction_valid),
      .dt_instruction        (dt_instruction),
      .dt_mask_value         (dt_mask_value),
      .dt_thread_idx         (dt_thread_idx),
      .dt_request_addr       (dt_request_addr),
      .dt_store_value        (dt_store_value),
      .dt_subcycle           (dt_subcycle),
      .dt_way_hit            (dt_way_hit),
      .dt_cache_hit          (dt_cache_hit)
`ifdef DCACHE_ALIGN_CHECK_EN
      ,
      .dt_alignment_fault    (dt_alignment_fault)
`endif
   );

`ifndef DCACHE_ALIGN_CHECK_EN
   assign dt_alignment_fault = 1'b0;
`endif

   typedef struct {
      logic                instValid;
      logic                isMem;
      memory_access_type_t mtype;
      scalar_t             base;
      scalar_t             imm;
      subcycle_t           sub;
      thread_idx_t         thread;
      logic                fillEn;
      l1d_set_idx_t        fillSet;
      l1d_way_idx_t        fillWay;
      l1d_tag_t            fillTag;
      logic                fillValid;
      logic                rbEn;
      thread_idx_t         rbThread;
      pipeline_sel_t       rbPipe;
      logic                expValid;
      scalar_t             expAddr;
      logic [3:0]          expHit;
      logic                expFault;
   } vec_t;

   typedef struct {
      logic                    valid;
      thread_idx_t             thread;
      subcycle_t               sub;
      logic [VECTOR_LANES-1:0] mask;
      scalar_t                 addr;
      vector_t                 store;
      logic [3:0]              hit;
      logic                    fault;
   } exp_t;

   vec_t vecs[$];
   exp_t scoreboard[$];
   int   vecCount  = 0;
   int   missCount = 0;

   function automatic vec_t makeVec(
      input logic iv, input logic im, input memory_access_type_t mt, input scalar_t base,
      input scalar_t imm, input subcycle_t sub, input thread_idx_t th,
      input logic fe, input l1d_set_idx_t fs, input l1d_way_idx_t fw, input l1d_tag_t ft,
      input logic fv, input logic rb, input thread_idx_t rbt, input pipeline_sel_t rbp,
      input logic ev, input scalar_t ea, input logic [3:0] eh, input logic ef);
      vec_t v;
      v.instValid = iv;  v.isMem = im;    v.mtype = mt;    v.base = base; v.imm = imm;
      v.sub = sub;       v.thread = th;   v.fillEn = fe;   v.fillSet = fs;
      v.fillWay = fw;    v.fillTag = ft;  v.fillValid = fv;
      v.rbEn = rb;       v.rbThread = rbt; v.rbPipe = rbp;
      v.expValid = ev;   v.expAddr = ea;  v.expHit = eh;   v.expFault = ef;
      return v;
   endfunction

   function automatic vector_t expStore(input memory_access_type_t mt, input subcycle_t sub,
                                        input vector_t sv);
      vector_t r;
      r = sv;
      if (mt == MEM_STRIDED || mt == MEM_SCGATH)
         r[0] = sv[sub];
      return r;
   endfunction

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cmpWide(input string name, input vector_t act, input vector_t exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drives one record onto the of_/fill/rollback inputs and queues what the stage must produce.
   task automatic applyStimulus(input vec_t v);
      exp_t e;
      of_instruction_valid                  = v.instValid;
      of_instruction                        = '0;
      of_instruction.is_memory_access       = v.isMem;
      of_instruction.is_load                = 1'b1;
      of_instruction.memory_access_type     = v.mtype;
      of_instruction.immediate_value        = v.imm;
      of_mask_value                         = 16'($urandom);
      of_thread_idx                         = v.thread;
      of_subcycle                           = v.sub;
      for (int i = 0; i < VECTOR_LANES; i++) begin
         of_operand1[i]    = v.base + 32'(4 * i);
         of_store_value[i] = $urandom;
      end
      fill_en                = v.fillEn;
      fill_set               = v.fillSet;
      fill_way               = v.fillWay;
      fill_tag               = v.fillTag;
      fill_valid             = v.fillValid;
      wb_rollback_en         = v.rbEn;
      wb_rollback_thread_idx = v.rbThread;
      wb_rollback_pipeline   = v.rbPipe;
      e.valid  = v.expValid;
      e.thread = v.thread;
      e.sub    = v.sub;
      e.mask   = of_mask_value;
      e.addr   = v.expAddr;
      e.store  = expStore(v.mtype, v.sub, of_store_value);
      e.hit    = v.expHit;
      e.fault  = v.expFault;
      scoreboard.push_back(e);
   endtask

   // Pops the oldest expectation and compares it with the registered stage outputs.
   task automatic checkOutput(input string tag);
      exp_t e;
      if (scoreboard.size() == 0) begin
         vecCount++;
         missCount++;
         $display("[TB] FAIL %s scoreboard: got 0 entries, expected 1", tag);
         return;
      end
      e = scoreboard.pop_front();
      cmp({tag, " valid"}, 64'(dt_instruction_valid), 64'(e.valid));
      if (e.valid) begin
         cmp({tag, " addr"}, 64'(dt_request_addr), 64'(e.addr));
         cmp({tag, " thread"}, 64'(dt_thread_idx), 64'(e.thread));
         cmp({tag, " subcycle"}, 64'(dt_subcycle), 64'(e.sub));
         cmp({tag, " mask"}, 64'(dt_mask_value), 64'(e.mask));
         cmpWide({tag, " store"}, dt_store_value, e.store);
      end
      cmp({tag, " way_hit"}, 64'(dt_way_hit), 64'(e.hit));
      cmp({tag, " cache_hit"}, 64'(dt_cache_hit), 64'(|e.hit));
      if (ALIGN_EN)
         cmp({tag, " align_fault"}, 64'(dt_alignment_fault), 64'(e.fault));
   endtask

   task automatic checkAllZero(input string tag);
      cmp({tag, " valid"}, 64'(dt_instruction_valid), 64'd0);
      cmp({tag, " instr"}, 64'(dt_instruction), 64'd0);
      cmp({tag, " mask"}, 64'(dt_mask_value), 64'd0);
      cmp({tag, " thread"}, 64'(dt_thread_idx), 64'd0);
      cmp({tag, " addr"}, 64'(dt_request_addr), 64'd0);
      cmpWide({tag, " store"}, dt_store_value, '0);
      cmp({tag, " subcycle"}, 64'(dt_subcycle), 64'd0);
      cmp({tag, " way_hit"}, 64'(dt_way_hit), 64'd0);
      cmp({tag, " cache_hit"}, 64'(dt_cache_hit), 64'd0);
      if (ALIGN_EN)
         cmp({tag, " align_fault"}, 64'(dt_alignment_fault), 64'd0);
   endtask

   task automatic runOne(input vec_t v, input string tag);
      applyStimulus(v);
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   initial begin
      logic [3:0] misHit;
      misHit = ALIGN_EN ? 4'b0000 : 4'b1000;

      // Table: fills, hits, lane-indexed addressing, gating, rollback and alignment.
      vecs.push_back(makeVec(0,0,MEM_L,32'h0,32'h0,0,0,         1,5,2,20'h01234,1, 0,0,PIPE_MEM, 0,32'h0,4'b0000,0));
      vecs.push_back(makeVec(1,1,MEM_L,32'h01234140,32'h0,0,1,  0,0,0,20'h0,0,     0,0,PIPE_MEM, 1,32'h01234140,4'b0100,0));
      vecs.push_back(makeVec(1,1,MEM_L,32'h01235140,32'h0,0,1,  0,0,0,20'h0,0,     0,0,PIPE_MEM, 1,32'h01235140,4'b0000,0));
      vecs.push_back(makeVec(1,1,MEM_SCGATH,32'h1000,32'h8,3,0, 0,0,0,20'h0,0,     0,0,PIPE_MEM, 1,32'h00001014,4'b0000,0));
      vecs.push_back(makeVec(1,1,MEM_STRIDED,32'h2000,32'h100,2,3,0,0,0,20'h0,0,   0,0,PIPE_MEM, 1,32'h00002200,4'b0000,0));
      vecs.push_back(makeVec(1,1,MEM_L,32'h10,32'hFFFFFFF0,0,0, 0,0,0,20'h0,0,     0,0,PIPE_MEM, 1,32'h00000000,4'b0000,0));
      vecs.push_back(makeVec(1,1,MEM_L,32'h00ABC240,32'h0,0,0,  1,9,0,20'h00ABC,1, 0,0,PIPE_MEM, 1,32'h00ABC240,4'b0001,0));
      vecs.push_back(makeVec(1,1,MEM_L,32'hFFFF0000,32'h0,0,0,  1,0,1,20'hFFFF0,1, 0,0,PIPE_MEM, 1,32'hFFFF0000,4'b0000,0));
      vecs.push_back(makeVec(1,0,MEM_L,32'h00ABC240,32'h0,0,0,  0,0,0,20'h0,0,     0,0,PIPE_MEM, 1,32'h00ABC240,4'b0000,0));
      vecs.push_back(makeVec(1,1,MEM_L,32'h01234140,32'h0,0,1,  1,5,2,20'h01234,0, 0,0,PIPE_MEM, 1,32'h01234140,4'b0000,0));
      vecs.push_back(makeVec(1,1,MEM_L,32'h00ABC240,32'h0,0,2,  0,0,0,20'h0,0,     1,2,PIPE_MEM, 0,32'h00ABC240,4'b0000,0));
      vecs.push_back(makeVec(1,1,MEM_L,32'h00ABC240,32'h0,0,1,  0,0,0,20'h0,0,     1,2,PIPE_MEM, 1,32'h00ABC240,4'b0001,0));
      vecs.push_back(makeVec(1,1,MEM_L,32'h00ABC240,32'h0,0,2,  0,0,0,20'h0,0,     1,2,PIPE_INT_ARITH, 1,32'h00ABC240,4'b0001,0));
      vecs.push_back(makeVec(1,1,MEM_BLOCK,32'h00ABC240,32'h0,0,0,0,0,0,20'h0,0,   0,0,PIPE_MEM, 1,32'h00ABC240,4'b0001,0));
      vecs.push_back(makeVec(0,0,MEM_L,32'h0,32'h0,0,0,         1,0,3,20'h00001,1, 0,0,PIPE_MEM, 0,32'h0,4'b0000,0));
      vecs.push_back(makeVec(1,1,MEM_L,32'h1000,32'h4,0,0,      0,0,0,20'h0,0,     0,0,PIPE_MEM, 1,32'h00001004,4'b1000,0));
      vecs.push_back(makeVec(1,1,MEM_L,32'h1000,32'h2,0,0,      0,0,0,20'h0,0,     0,0,PIPE_MEM, 1,32'h00001002,misHit,ALIGN_EN));
      vecs.push_back(makeVec(1,1,MEM_S,32'h1000,32'h1,0,0,      0,0,0,20'h0,0,     0,0,PIPE_MEM, 1,32'h00001001,misHit,ALIGN_EN));
      vecs.push_back(makeVec(1,1,MEM_BLOCK,32'h1000,32'h4,0,0,  0,0,0,20'h0,0,     0,0,PIPE_MEM, 1,32'h00001004,misHit,ALIGN_EN));
      vecs.push_back(makeVec(1,1,MEM_B,32'h1000,32'h3,0,0,      0,0,0,20'h0,0,     0,0,PIPE_MEM, 1,32'h00001003,4'b1000,0));
      vecs.push_back(makeVec(1,1,MEM_SX,32'h1000,32'h2,0,0,     0,0,0,20'h0,0,     0,0,PIPE_MEM, 1,32'h00001002,4'b1000,0));

      // Reset with live-looking inputs: every output must stay at zero.
      reset = 1'b1;
      applyStimulus(makeVec(1,1,MEM_L,32'h01234140,32'h0,5,3, 1,5,2,20'h01234,1, 0,0,PIPE_MEM, 0,32'h0,4'b0,0));
      void'(scoreboard.pop_back());
      repeat (2) @(posedge clk);
      #1;
      checkAllZero("reset0");
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++)
         runOne(vecs[i], $sformatf("vec%0d", i));

      // Fill all four ways of set 7, confirm each hits, then reset with a fill in flight.
      for (int w = 0; w < 4; w++)
         runOne(makeVec(0,0,MEM_L,32'h0,32'h0,0,0, 1,7,l1d_way_idx_t'(w),l1d_tag_t'(20'h10 + w),1,
                        0,0,PIPE_MEM, 0,32'h0,4'b0,0), $sformatf("fill%0d", w));
      for (int w = 0; w < 4; w++)
         runOne(makeVec(1,1,MEM_L,32'h000101C0 + 32'(w * 32'h1000),32'h0,0,0, 0,0,0,20'h0,0,
                        0,0,PIPE_MEM, 1,32'h000101C0 + 32'(w * 32'h1000),4'(1 << w),0),
                $sformatf("prehit%0d", w));

      applyStimulus(makeVec(1,1,MEM_L,32'h000101C0,32'h0,0,1, 1,8,0,20'h00020,1, 0,0,PIPE_MEM, 0,32'h0,4'b0,0));
      void'(scoreboard.pop_back());
      #3;
      reset = 1'b1;
      #1;
      checkAllZero("resetAsync");
      @(posedge clk);
      #1;
      checkAllZero("resetHeld");
      reset = 1'b0;

      for (int w = 0; w < 4; w++)
         runOne(makeVec(1,1,MEM_L,32'h000101C0 + 32'(w * 32'h1000),32'h0,0,0, 0,0,0,20'h0,0,
                        0,0,PIPE_MEM, 1,32'h000101C0 + 32'(w * 32'h1000),4'b0000,0),
                $sformatf("postreset%0d", w));
      runOne(makeVec(1,1,MEM_L,32'h00020200,32'h0,0,0, 0,0,0,20'h0,0,
                     0,0,PIPE_MEM, 1,32'h00020200,4'b0000,0), "droppedFill");

      if (scoreboard.size() != 0) begin
         vecCount++;
         missCount++;
         $display("[TB] FAIL scoreboard drain: got %0d entries, expected 0", scoreboard.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
